// File: rtl/weyl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weyl_pkg
// Description : Shared constants and types for the Weyl bit serializer.
// Revision    : 1.0
// ============================================================================
package weyl_pkg;

    localparam int C_BITSTREAM = 64;
    localparam int C_CNT_W     = $clog2(C_BITSTREAM) + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

    typedef struct packed {
        logic [C_BITSTREAM-1:0] pattern;
        logic [C_CNT_W-1:0]     quota;
    } weyl_word_t;

endpackage
`default_nettype wire

// File: rtl/weyl_bit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : weyl_bit_serializer_if
// Description : Pattern input handshake and serial bit output bundle.
// Revision    : 1.0
// ============================================================================
interface weyl_bit_serializer_if
    import weyl_pkg::*;
#(
    parameter int BITSTREAM = C_BITSTREAM,
    parameter int CNT_W     = $clog2(BITSTREAM) + 1
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [BITSTREAM-1:0] in_pattern;
    logic [CNT_W-1:0]     in_quota;
    logic                 out_ready;
    logic                 bit_valid;
    logic                 bit_out;
    logic                 bit_sos;
    logic                 bit_eos;
    logic [CNT_W-1:0]     ones_count;
    logic                 count_valid;
    logic                 mismatch;

    modport master (
        output in_valid, in_pattern, in_quota, out_ready,
        input  in_ready, bit_valid, bit_out, bit_sos, bit_eos,
               ones_count, count_valid, mismatch
    );

    modport slave (
        input  in_valid, in_pattern, in_quota, out_ready,
        output in_ready, bit_valid, bit_out, bit_sos, bit_eos,
               ones_count, count_valid, mismatch
    );

endinterface
`default_nettype wire

// File: rtl/weyl_pattern_buf.sv
`default_nettype none
// ============================================================================
// Module      : weyl_pattern_buf
// Description : Two-entry active/shadow pattern store for the serializer.
// Revision    : 1.0
// ============================================================================
module weyl_pattern_buf #(
    parameter int BITSTREAM = 64,
    parameter int CNT_W     = $clog2(BITSTREAM) + 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_wr_en,
    input  wire logic [BITSTREAM-1:0] i_wr_pattern,
    input  wire logic [CNT_W-1:0]     i_wr_quota,
    input  wire logic                 i_promote,
    output logic                      o_in_ready,
    output logic                      o_shadow_full,
    output logic [BITSTREAM-1:0]      o_act_pattern,
    output logic [CNT_W-1:0]          o_act_quota
);

    logic [BITSTREAM-1:0] r_act_pattern;
    logic [CNT_W-1:0]     r_act_quota;
    logic [BITSTREAM-1:0] r_shd_pattern;
    logic [CNT_W-1:0]     r_shd_quota;
    logic                 r_shd_full;

    // Promotion reads the old shadow; a same-cycle write refills it, so the
    // later assignment to r_shd_full must win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_pattern <= '0;
            r_act_quota   <= '0;
            r_shd_pattern <= '0;
            r_shd_quota   <= '0;
            r_shd_full    <= 1'b0;
        end else begin
            if (i_promote) begin
                r_act_pattern <= r_shd_pattern;
                r_act_quota   <= r_shd_quota;
                r_shd_full    <= 1'b0;
            end
            if (i_wr_en) begin
                r_shd_pattern <= i_wr_pattern;
                r_shd_quota   <= i_wr_quota;
                r_shd_full    <= 1'b1;
            end
        end
    end

    assign o_in_ready    = ~r_shd_full;
    assign o_shadow_full = r_shd_full;
    assign o_act_pattern = r_act_pattern;
    assign o_act_quota   = r_act_quota;

endmodule
`default_nettype wire

// File: rtl/weyl_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : weyl_bit_serializer
// Description : Serializes Weyl patterns LSB-first and checks ones vs quota.
// Revision    : 1.0
// ============================================================================
module weyl_bit_serializer
    import weyl_pkg::*;
#(
    parameter int BITSTREAM = C_BITSTREAM,
    parameter int CNT_W     = $clog2(BITSTREAM) + 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    weyl_bit_serializer_if.slave   bus
);

    localparam int                 C_IDX_W    = $clog2(BITSTREAM);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(BITSTREAM - 1);

    ser_state_t           r_state;
    logic [C_IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_ones_count;
    logic                 r_count_valid;
    logic                 r_mismatch;

    logic                 w_in_ready;
    logic                 w_shadow_full;
    logic [BITSTREAM-1:0] w_act_pattern;
    logic [CNT_W-1:0]     w_act_quota;
    logic                 w_wr_en;
    logic                 w_streaming;
    logic                 w_bit;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_promote;
    logic [CNT_W-1:0]     w_final;

    assign w_wr_en     = bus.in_valid & w_in_ready;
    assign w_streaming = (r_state == STREAM);
    assign w_bit       = w_streaming & w_act_pattern[r_idx];
    assign w_xfer      = w_streaming & bus.out_ready;
    assign w_last      = w_xfer & (r_idx == C_LAST_IDX);
    assign w_final     = r_acc + CNT_W'(w_bit);
    // The shadow entry moves up either from idle or right behind the eos bit.
    assign w_promote   = w_shadow_full & ((r_state == IDLE) | w_last);

    weyl_pattern_buf #(
        .BITSTREAM (BITSTREAM),
        .CNT_W     (CNT_W)
    ) u_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_en       (w_wr_en),
        .i_wr_pattern  (bus.in_pattern),
        .i_wr_quota    (bus.in_quota),
        .i_promote     (w_promote),
        .o_in_ready    (w_in_ready),
        .o_shadow_full (w_shadow_full),
        .o_act_pattern (w_act_pattern),
        .o_act_quota   (w_act_quota)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_acc         <= '0;
            r_ones_count  <= '0;
            r_count_valid <= 1'b0;
            r_mismatch    <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_shadow_full) begin
                        r_state <= STREAM;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                STREAM: begin
                    if (w_last) begin
                        r_ones_count  <= w_final;
                        r_mismatch    <= (w_final != w_act_quota);
                        r_count_valid <= 1'b1;
                        r_acc         <= '0;
                        r_idx         <= '0;
                        r_state       <= w_shadow_full ? STREAM : IDLE;
                    end else if (w_xfer) begin
                        r_acc <= w_final;
                        r_idx <= r_idx + C_IDX_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.bit_valid   = w_streaming;
    assign bus.bit_out     = w_bit;
    assign bus.bit_sos     = w_streaming & (r_idx == '0);
    assign bus.bit_eos     = w_streaming & (r_idx == C_LAST_IDX);
    assign bus.ones_count  = r_ones_count;
    assign bus.count_valid = r_count_valid;
    assign bus.mismatch    = r_mismatch;

endmodule
`default_nettype wire
